// File: rtl/axis_ifmaps_packer.sv
// Ifmaps preload buffer: unpacks AXIS beats into MAC_NUM-lane rows and queues
// the completed rows in a FIFO_DEPTH-entry row FIFO drained by the MAC array.
module axis_ifmaps_packer #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int ELEM_W               = 5,
  parameter int MAC_NUM              = 256,
  parameter int FIFO_DEPTH           = 4,
  localparam int ELEMS_PER_BEAT      = C_S_AXIS_TDATA_WIDTH / ELEM_W,
  localparam int CNT_W               = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic [11:0]                       channel_size,
  input  logic                              clear,
  output logic [ELEM_W*MAC_NUM-1:0]         ifmaps_out,
  input  logic                              mac_read,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [CNT_W-1:0]                  fifo_count,
  output logic                              tlast_err
);

  localparam int MAX_BEATS = (MAC_NUM + ELEMS_PER_BEAT - 1) / ELEMS_PER_BEAT;
  localparam int BC_W      = $clog2(MAX_BEATS + 1);
  localparam int CS_W      = $clog2(MAC_NUM + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int ROW_W     = ELEM_W * MAC_NUM;
  localparam int USED_W    = ELEMS_PER_BEAT * ELEM_W;

  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [ROW_W-1:0] asm_row;
  logic [ROW_W-1:0] row_next;
  logic [BC_W-1:0]  beat_cnt;
  logic [BC_W-1:0]  last_beat;
  logic [CS_W-1:0]  eff_cs;
  logic [CS_W-1:0]  cs_in;
  logic [CS_W-1:0]  cs_cur;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             at_last;
  logic             accept;
  logic             push;
  logic             pop;

  generate
    if (C_S_AXIS_TDATA_WIDTH > USED_W) begin : g_unused_hi
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s_axis_tdata[C_S_AXIS_TDATA_WIDTH-1:USED_W];
    end
  endgenerate

  // Channel count applies live on beat 0 and is frozen for the rest of the row.
  assign cs_in  = (channel_size == 12'd0 || int'(channel_size) > MAC_NUM) ?
                  CS_W'(MAC_NUM) : CS_W'(channel_size);
  assign cs_cur = (beat_cnt == '0) ? cs_in : eff_cs;

  assign last_beat = BC_W'((int'(cs_cur) + ELEMS_PER_BEAT - 1) / ELEMS_PER_BEAT - 1);
  assign at_last   = (beat_cnt == last_beat);

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_count    = count;
  assign s_axis_tready = ~clear & (~fifo_full | ~at_last);

  assign accept = s_axis_tvalid & s_axis_tready;
  assign push   = accept & (at_last | s_axis_tlast);
  assign pop    = mac_read & ~fifo_empty & ~clear;

  assign ifmaps_out = mem[rd_ptr];

  always_comb begin
    row_next = (beat_cnt == '0) ? '0 : asm_row;
    for (int i = 0; i < MAC_NUM; i++) begin
      if ((i / ELEMS_PER_BEAT) == int'(beat_cnt) && i < int'(cs_cur))
        row_next[i*ELEM_W +: ELEM_W] = s_axis_tdata[(i % ELEMS_PER_BEAT)*ELEM_W +: ELEM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= row_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_row   <= '0;
      beat_cnt  <= '0;
      eff_cs    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tlast_err <= 1'b0;
    end else if (clear) begin
      asm_row   <= '0;
      beat_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tlast_err <= 1'b0;
    end else begin
      if (accept) begin
        if (beat_cnt == '0) eff_cs <= cs_in;
        if (push) begin
          beat_cnt <= '0;
          asm_row  <= '0;
          wr_ptr   <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          // Early tlast and missing tlast are both framing errors.
          if (at_last != s_axis_tlast) tlast_err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          asm_row  <= row_next;
        end
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
